// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Detects read-after-write hazards between the ID-stage source registers and
// the EX/MEM in-flight write-back destinations, and drives the pipeline stall
// line. A two-state FSM with a small down-counter sustains multi-cycle stalls
// so the shifting stage summaries are not re-evaluated mid-stall. Two
// saturating counters record stall cycles and new hazard detections.

module hazard_stall_unit #(
    parameter int          FORWARD   = 0,
    parameter logic [5:0]  LOAD_TYPE = 6'd10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_flush,
    input  logic [4:0]  id_rs,
    input  logic        id_rs_used,
    input  logic [4:0]  id_rt,
    input  logic        id_rt_used,
    input  logic [5:0]  EX_insType,
    input  logic [4:0]  EX_WBDest,
    input  logic [5:0]  MEM_insType,
    input  logic [4:0]  MEM_WBDest,
    output logic        stall,
    output logic [15:0] stall_cycles,
    output logic [15:0] hazard_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_e      state_q, state_d;
    logic [1:0]  remain_q, remain_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] hazard_count_q, hazard_count_d;

    logic        ex_hit;
    logic        mem_hit;
    logic [1:0]  need;
    logic        stall_d;
    logic        new_hazard;

    // A stage produces register src when it holds a real instruction that
    // writes src, and src is not the hardwired zero register.
    function automatic logic produces(input logic [5:0] ins_type,
                                      input logic [4:0] wb_dest,
                                      input logic [4:0] src);
        return (ins_type != 6'd0) && (wb_dest == src) && (src != 5'd0);
    endfunction

    // Match ID sources against the EX and MEM producers.
    always_comb begin
        ex_hit  = (id_rs_used && produces(EX_insType, EX_WBDest, id_rs)) ||
                  (id_rt_used && produces(EX_insType, EX_WBDest, id_rt));
        mem_hit = (id_rs_used && produces(MEM_insType, MEM_WBDest, id_rs)) ||
                  (id_rt_used && produces(MEM_insType, MEM_WBDest, id_rt));
    end

    // Number of bubbles the ID instruction needs before its operands are ready.
    // Without forwarding, a WB-stage producer is covered by the split-cycle
    // register file, so only EX (2 bubbles) and MEM (1 bubble) matter.
    always_comb begin
        need = 2'd0;
        if (FORWARD == 0) begin
            if (ex_hit) begin
                need = 2'd2;
            end else if (mem_hit) begin
                need = 2'd1;
            end
        end else if (ex_hit && (EX_insType == LOAD_TYPE)) begin
            need = 2'd1;
        end
    end

    // Stall FSM: first stall cycle comes straight from detection, the rest
    // from the remain counter. Flush and reset force stall low immediately.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d    = state_q;
        remain_d   = remain_q;
        stall_d    = 1'b0;
        new_hazard = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    if (id_flush) begin
                        remain_d = 2'd0;
                    end else if (need != 2'd0) begin
                        stall_d    = 1'b1;
                        new_hazard = 1'b1;
                        remain_d   = need - 2'd1;
                        if (need != 2'd1) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (id_flush) begin
                        state_d  = IDLE;
                        remain_d = 2'd0;
                    end else begin
                        stall_d = 1'b1;
                        if (remain_q <= 2'd1) begin
                            state_d  = IDLE;
                            remain_d = 2'd0;
                        end else begin
                            remain_d = remain_q - 2'd1;
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    remain_d = 2'd0;
                end
            endcase
        end
    end

    // Saturating event counters for performance debug.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        hazard_count_d = hazard_count_q;
        if (stall_d && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (new_hazard && (hazard_count_q != CNT_MAX)) begin
            hazard_count_d = hazard_count_q + 16'd1;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its next value from the same pre-edge snapshot.
        if (!rst_n) begin
            state_q        <= IDLE;
            remain_q       <= 2'd0;
            stall_cycles_q <= 16'd0;
            hazard_count_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            remain_q       <= remain_d;
            stall_cycles_q <= stall_cycles_d;
            hazard_count_q <= hazard_count_d;
        end
    end

    assign stall        = stall_d;
    assign stall_cycles = stall_cycles_q;
    assign hazard_count = hazard_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit. Two instances (no forwarding / forwarding)
// share one stimulus stream. Expected stall values are pushed to a scoreboard
// queue as each cycle is driven; the checker pops them shortly before the
// next rising edge and compares stall plus both counters.

module tb_hazard_stall_unit;

    logic        clk;
    logic        rst_n;
    logic        id_flush;
    logic [4:0]  id_rs;
    logic        id_rs_used;
    logic [4:0]  id_rt;
    logic        id_rt_used;
    logic [5:0]  EX_insType;
    logic [4:0]  EX_WBDest;
    logic [5:0]  MEM_insType;
    logic [4:0]  MEM_WBDest;

    logic        stall_nf, stall_fw;
    logic [15:0] sc_nf, sc_fw;
    logic [15:0] hc_nf, hc_fw;

    hazard_stall_unit #(.FORWARD(0), .LOAD_TYPE(6'd10)) u_dut_nf (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_flush     (id_flush),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .id_rt        (id_rt),
        .id_rt_used   (id_rt_used),
        .EX_insType   (EX_insType),
        .EX_WBDest    (EX_WBDest),
        .MEM_insType  (MEM_insType),
        .MEM_WBDest   (MEM_WBDest),
        .stall        (stall_nf),
        .stall_cycles (sc_nf),
        .hazard_count (hc_nf)
    );

    hazard_stall_unit #(.FORWARD(1), .LOAD_TYPE(6'd10)) u_dut_fw (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_flush     (id_flush),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .id_rt        (id_rt),
        .id_rt_used   (id_rt_used),
        .EX_insType   (EX_insType),
        .EX_WBDest    (EX_WBDest),
        .MEM_insType  (MEM_insType),
        .MEM_WBDest   (MEM_WBDest),
        .stall        (stall_fw),
        .stall_cycles (sc_fw),
        .hazard_count (hc_fw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        s_nf;
        logic [15:0] c_nf;
        logic [15:0] h_nf;
        logic        s_fw;
        logic [15:0] c_fw;
        logic [15:0] h_fw;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_sc_nf  = 16'd0;
    logic [15:0] m_hc_nf  = 16'd0;
    logic [15:0] m_sc_fw  = 16'd0;
    logic [15:0] m_hc_fw  = 16'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic set_in(input logic fl,
                          input logic [4:0] rs, input logic rs_u,
                          input logic [4:0] rt, input logic rt_u,
                          input logic [5:0] ex_t, input logic [4:0] ex_d,
                          input logic [5:0] mem_t, input logic [4:0] mem_d);
        id_flush    = fl;
        id_rs       = rs;
        id_rs_used  = rs_u;
        id_rt       = rt;
        id_rt_used  = rt_u;
        EX_insType  = ex_t;
        EX_WBDest   = ex_d;
        MEM_insType = mem_t;
        MEM_WBDest  = mem_d;
    endtask

    task automatic clear_in();
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 6'd0, 5'd0, 6'd0, 5'd0);
    endtask

    // EX producer of r5 (type 3) read through rs.
    task automatic ex_hit_in(input logic fl);
        set_in(fl, 5'd5, 1'b1, 5'd0, 1'b0, 6'd3, 5'd5, 6'd0, 5'd0);
    endtask

    // Push expected values for the cycle just driven, advance the counter
    // model, then wait for the next driving point.
    task automatic step(input string tag,
                        input logic s_nf, input logic hz_nf,
                        input logic s_fw, input logic hz_fw);
        exp_t e;
        e.tag  = tag;
        e.s_nf = s_nf;
        e.c_nf = m_sc_nf;
        e.h_nf = m_hc_nf;
        e.s_fw = s_fw;
        e.c_fw = m_sc_fw;
        e.h_fw = m_hc_fw;
        sb.push_back(e);
        if (!rst_n) begin
            m_sc_nf = 16'd0;
            m_hc_nf = 16'd0;
            m_sc_fw = 16'd0;
            m_hc_fw = 16'd0;
        end else begin
            if (s_nf)  m_sc_nf = sat_inc(m_sc_nf);
            if (hz_nf) m_hc_nf = sat_inc(m_hc_nf);
            if (s_fw)  m_sc_fw = sat_inc(m_sc_fw);
            if (hz_fw) m_hc_fw = sat_inc(m_hc_fw);
        end
        @(negedge clk);
    endtask

    // Checker: compare 1 time unit before each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, ".stall_nf"}, {31'd0, stall_nf}, {31'd0, e.s_nf});
                check({e.tag, ".sc_nf"},    {16'd0, sc_nf},    {16'd0, e.c_nf});
                check({e.tag, ".hc_nf"},    {16'd0, hc_nf},    {16'd0, e.h_nf});
                check({e.tag, ".stall_fw"}, {31'd0, stall_fw}, {31'd0, e.s_fw});
                check({e.tag, ".sc_fw"},    {16'd0, sc_fw},    {16'd0, e.c_fw});
                check({e.tag, ".hc_fw"},    {16'd0, hc_fw},    {16'd0, e.h_fw});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        ex_hit_in(1'b0);
        @(negedge clk);

        // Reset held with a live hazard: no stall, counters zero.
        for (int i = 0; i < 3; i++) step("rst_hold", 0, 0, 0, 0);

        // Release with EX hit still visible: 2-cycle stall without forwarding,
        // none with forwarding (type 3 is not a load).
        rst_n = 1'b1;
        step("ex_hit_c1", 1, 1, 0, 0);
        clear_in();
        step("ex_hit_c2", 1, 0, 0, 0);
        step("ex_hit_end", 0, 0, 0, 0);

        // MEM-only hit on rt: 1 cycle.
        set_in(1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 6'd0, 5'd0, 6'd3, 5'd9);
        step("mem_hit", 1, 1, 0, 0);
        clear_in();
        step("mem_hit_end", 0, 0, 0, 0);

        // EX hit on rs plus MEM hit on rt: 2 cycles.
        set_in(1'b0, 5'd5, 1'b1, 5'd9, 1'b1, 6'd3, 5'd5, 6'd3, 5'd9);
        step("ex_mem_c1", 1, 1, 0, 0);
        clear_in();
        step("ex_mem_c2", 1, 0, 0, 0);
        step("ex_mem_end", 0, 0, 0, 0);

        // Load-use in EX on rt: forwarding instance stalls 1 cycle.
        set_in(1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 6'd10, 5'd7, 6'd0, 5'd0);
        step("load_use", 1, 1, 1, 1);
        clear_in();
        step("load_use_c2", 1, 0, 0, 0);
        step("load_use_end", 0, 0, 0, 0);

        // Non-load EX producer: forwarding covers it.
        set_in(1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 6'd3, 5'd7, 6'd0, 5'd0);
        step("fw_alu", 1, 1, 0, 0);
        clear_in();
        step("fw_alu_c2", 1, 0, 0, 0);
        step("fw_alu_end", 0, 0, 0, 0);

        // Load in MEM: forwarding covers it.
        set_in(1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 6'd0, 5'd0, 6'd10, 5'd7);
        step("fw_mem_load", 1, 1, 0, 0);
        clear_in();
        step("fw_mem_load_end", 0, 0, 0, 0);

        // No false hazards: r0, bubble, unused source.
        set_in(1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 6'd10, 5'd0, 6'd10, 5'd0);
        step("r0_dest", 0, 0, 0, 0);
        set_in(1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 6'd0, 5'd5, 6'd0, 5'd5);
        step("bubble", 0, 0, 0, 0);
        set_in(1'b0, 5'd5, 1'b0, 5'd6, 1'b0, 6'd10, 5'd5, 6'd10, 5'd6);
        step("unused_src", 0, 0, 0, 0);

        // Back-to-back: hazard held across the HOLD->IDLE return re-stalls
        // with no gap.
        ex_hit_in(1'b0);
        step("b2b_c1", 1, 1, 0, 0);
        step("b2b_c2", 1, 0, 0, 0);
        step("b2b_c3", 1, 1, 0, 0);
        clear_in();
        step("b2b_c4", 1, 0, 0, 0);
        step("b2b_end", 0, 0, 0, 0);

        // Flush in the second stall cycle: stall drops, FSM back in IDLE.
        ex_hit_in(1'b0);
        step("flush_c1", 1, 1, 0, 0);
        ex_hit_in(1'b1);
        step("flush_c2", 0, 0, 0, 0);
        clear_in();
        step("flush_idle", 0, 0, 0, 0);

        // Flush in IDLE with a live hazard: no stall, no detection counted.
        ex_hit_in(1'b1);
        step("flush_idle_hz", 0, 0, 0, 0);
        clear_in();
        step("flush_idle_end", 0, 0, 0, 0);

        // Reset mid-HOLD aborts the stall in the same cycle.
        ex_hit_in(1'b0);
        step("rst_hold_c1", 1, 1, 0, 0);
        rst_n = 1'b0;
        step("rst_mid_hold", 0, 0, 0, 0);
        rst_n = 1'b1;
        clear_in();
        step("rst_after", 0, 0, 0, 0);
        step("rst_after2", 0, 0, 0, 0);

        // Long continuous stall drives stall_cycles into saturation.
        ex_hit_in(1'b0);
        for (int i = 0; i < 65540; i++) begin
            step("sat_run", 1, ((i % 2) == 0), 0, 0);
        end
        clear_in();
        step("sat_end", 0, 0, 0, 0);
        step("sat_hold", 0, 0, 0, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        check("sat_value", {16'd0, sc_nf}, 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Reads the in-flight instruction summaries published by the micro-instruction transfer line: instruction type and write-back destination for the EX and MEM stages. Compares them against the source registers of the instruction in ID and drives the `stall` line back into the transfer line and the IF/ID hold logic. A small counter FSM sustains multi-cycle stalls without re-evaluating summaries that are already shifting. Saturating event counters are kept for performance debug.

## Interface

Parameters:
- `FORWARD`, default 0: 1 means an EX/MEM→EX forwarding network exists; 0 means the register file is the only data source.
- `LOAD_TYPE`, default 6'd10: insType code of the load instruction.

Ports:
- `clk`  in  1  Clock. Single clock domain, rising edge.
- `rst_n`  in  1  Reset. Synchronous, active-low.
- `id_flush`  in  1  ID instruction squashed (taken branch/jump). Cancels any pending stall.
- `id_rs`  in  5  Source register 1 of the ID instruction.
- `id_rs_used`  in  1  `id_rs` is actually read.
- `id_rt`  in  5  Source register 2 of the ID instruction.
- `id_rt_used`  in  1  `id_rt` is actually read.
- `EX_insType`  in  6  EX-stage instruction type. 0 = bubble.
- `EX_WBDest`  in  5  EX-stage write-back register.
- `MEM_insType`  in  6  MEM-stage instruction type. 0 = bubble.
- `MEM_WBDest`  in  5  MEM-stage write-back register.
- `stall`  out  1  Insert bubble into transfer line; hold PC and IF/ID.
- `stall_cycles`  out  16  Saturating count of cycles with `stall`=1.
- `hazard_count`  out  16  Saturating count of new hazard detections.

## Operation

Producer/consumer match:
- A stage is a producer for register r iff its insType ≠ 0, its WBDest = r, and r ≠ 0.
- `ex_hit` = (id_rs_used & EX producer of id_rs) | (id_rt_used & EX producer of id_rt). `mem_hit` is the same, using MEM.

Required bubbles `need`, computed combinationally:
- FORWARD=0: `ex_hit` → 2; else `mem_hit` → 1; else 0. The register file writes in the first half-cycle and reads in the second, so a WB-stage producer needs no stall.
- FORWARD=1: `ex_hit` with EX_insType = LOAD_TYPE → 1; otherwise 0.

FSM states are IDLE and HOLD, with a 2-bit `remain` counter.

IDLE:
- `stall` = (need ≠ 0) & ~id_flush.
- If `stall`=1: `remain` ← need−1 and `hazard_count`+1.
- Go to HOLD iff need−1 ≠ 0; else stay in IDLE.

HOLD:
- `stall` = ~id_flush. Source comparisons are ignored.
- `remain` decrements each cycle.
- Return to IDLE when `remain` reaches 0 or `id_flush`=1. Flush also clears `remain`.

Counters:
- `stall_cycles` increments in every cycle where `stall`=1.
- Both counters saturate at 16'hFFFF and never wrap.

## Timing

- The first stall cycle is combinational, in the same cycle the hazard is visible. Later stall cycles come from registered state.
- Stall lengths:
  - FORWARD=0, EX hit: `stall`=1 for exactly 2 consecutive cycles.
  - FORWARD=0, MEM-only hit: 1 cycle.
  - FORWARD=1, load-use: 1 cycle.
- Back-to-back hazards: on the cycle after HOLD returns to IDLE, detection resumes. A new hazard stalls with no gap.
- Flush has priority over everything. When `id_flush`=1, `stall`=0 in that cycle and the FSM is in IDLE next cycle.
- Reset, while `rst_n`=0:
  - `stall`=0, regardless of inputs.
  - Next state is IDLE, `remain`=0, `stall_cycles`=0, `hazard_count`=0.
- Reset asserted mid-HOLD aborts the stall in that same cycle.

## Test plan

1. **Reset.** Hold `rst_n`=0 with EX_insType=3, EX_WBDest=5, id_rs=5, id_rs_used=1 → `stall`=0 throughout. After release, both counters read 0 and `stall` follows detection.
2. **FORWARD=0, EX hit.** EX_insType=3, EX_WBDest=5, id_rs=5, id_rs_used=1 → `stall`=1 for 2 cycles, then 0. `stall_cycles`=2, `hazard_count`=1.
3. **FORWARD=0, MEM-only hit.** MEM_insType=3, MEM_WBDest=9, id_rt=9, id_rt_used=1 → `stall` for 1 cycle. An EX hit on rs plus a MEM hit on rt in the same cycle → 2 cycles.
4. **FORWARD=1.**
   - EX_insType=10 (load), EX_WBDest=7, id_rt=7, used → 1-cycle stall.
   - EX_insType=3 with the same dest → no stall.
   - MEM load hit → no stall.
5. **No false hazards.**
   - EX_WBDest=0 with id_rs=0 → no stall.
   - EX_insType=0 (bubble) with a matching dest → no stall.
   - Matching dest with id_rs_used=0 → no stall.
6. **Flush in HOLD.** Start an FSM=0 EX hit, then assert `id_flush` in the second stall cycle → `stall`=0 that cycle, IDLE next, `stall_cycles`=1. Also drive `stall_cycles` preset to 16'hFFFF via a long hold → it stays at 16'hFFFF.
